// File: rtl/prio_pkg.sv
// Shared types and helpers for the priority request capture front-end.
package prio_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned IDX_W_DEF   = 2;
  localparam int unsigned ONEHOT_W    = 32;

  // Wide one-hot; callers size-cast down to their request width.
  function automatic logic [ONEHOT_W-1:0] onehot(input logic [ONEHOT_W-1:0] idx);
    return {{(ONEHOT_W-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational highest-set-bit encoder with an any-set flag.
module prio_enc_n #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_vec,
  output logic [IDX_W-1:0]   idx,
  output logic               any_set
);

  // Ascending scan: the last (highest) set bit overwrites lower ones.
  always_comb begin
    idx     = '0;
    any_set = |req_vec;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/priority_request_capture.sv
// Sticky request capture with highest-index-first offer on a valid/ready handshake.
module priority_request_capture
  import prio_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned IDX_W   = IDX_W_DEF
) (
  input  logic               Clock_In,
  input  logic               Reset_n_In,
  input  logic               Enable_In,
  input  logic               Clear_In,
  input  logic [NUM_REQ-1:0] Request_In,
  input  logic               Ready_In,
  output logic               Valid_Out,
  output logic [IDX_W-1:0]   Index_Out,
  output logic [NUM_REQ-1:0] Pending_Out,
  output logic               Overflow_Out
);

  state_t             state_q;
  logic [NUM_REQ-1:0] pending_q;
  logic [IDX_W-1:0]   index_q;
  logic               valid_q;
  logic               overflow_q;

  logic               accept;
  logic [NUM_REQ-1:0] cap;
  logic [NUM_REQ-1:0] acc_mask;
  logic [NUM_REQ-1:0] pending_next;
  logic               ovf_hit;
  logic [IDX_W-1:0]   enc_idx;
  logic               any_set;

  always_comb begin
    accept       = valid_q && Ready_In;
    cap          = Enable_In ? Request_In : '0;
    acc_mask     = accept ? NUM_REQ'(onehot(ONEHOT_W'(index_q))) : '0;
    // Set wins over clear when a bit re-arrives on its own accept cycle.
    pending_next = (pending_q & ~acc_mask) | cap;
    ovf_hit      = |(cap & pending_q & ~acc_mask);
  end

  prio_enc_n #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_enc (
    .req_vec (pending_next),
    .idx     (enc_idx),
    .any_set (any_set)
  );

  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      index_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (Clear_In) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pending_q <= pending_next;
      if (ovf_hit) overflow_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (any_set) begin
            state_q <= OFFER;
            valid_q <= 1'b1;
            index_q <= enc_idx;
          end
        end
        OFFER: begin
          // Offered index is frozen until accepted; no pre-emption.
          if (accept) begin
            if (any_set) begin
              index_q <= enc_idx;
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign Valid_Out    = valid_q;
  assign Index_Out    = index_q;
  assign Pending_Out  = pending_q;
  assign Overflow_Out = overflow_q;

endmodule

// File: doc/priority_request_capture.md
Name: priority_request_capture

Overview:
- Sequential front-end for the 4:2 high-priority encoder path.
- Captures single-cycle request pulses into sticky pending bits, priority-encodes them (highest index wins) and offers one index at a time on a valid/ready handshake.
- Clears each serviced bit on acceptance.
- Sits between asynchronous-origin event sources (already synchronised) and a downstream index consumer/dispatcher.

Parameters:
- NUM_REQ, 4, number of request lines; bit NUM_REQ-1 has the highest priority, bit 0 the lowest.
- IDX_W, 2, width of the encoded index; must equal clog2(NUM_REQ).

Ports:
- Clock_In, input, 1, single clock; all state updates on the rising edge.
- Reset_n_In, input, 1, asynchronous active-low reset; deassertion is synchronised externally.
- Enable_In, input, 1, capture enable; when low, Request_In is ignored. Offer and handshake continue.
- Clear_In, input, 1, synchronous flush of all pending state.
- Request_In, input, NUM_REQ, request pulses sampled each cycle.
- Ready_In, input, 1, consumer accepts the offered index.
- Valid_Out, output, 1, Index_Out holds a valid request index.
- Index_Out, output, IDX_W, encoded index of the offered request.
- Pending_Out, output, NUM_REQ, current sticky pending vector, including the offered bit.
- Overflow_Out, output, 1, sticky flag: a request arrived on a bit that was already pending.

Behaviour:
- Reset (Reset_n_In low, asynchronous):
  - pending = 0, state = IDLE.
  - Valid_Out = 0, Index_Out = 0, Overflow_Out = 0, Pending_Out = 0.
  - Reset mid-offer drops the offer immediately. No acceptance is implied.
- Capture:
  - cap = Enable_In ? Request_In : 0.
  - pending_next = (pending & ~acc_mask) | cap.
  - acc_mask is the one-hot of Index_Out when Valid_Out && Ready_In, else 0.
  - Set wins: if a request re-arrives on the bit being accepted in the same cycle, that bit stays pending.
- States:
  - IDLE: Valid_Out = 0. If pending_next != 0, go to OFFER at the edge and register Index_Out = enc(pending_next).
  - OFFER: Valid_Out = 1.
    - Index_Out is held stable until acceptance; a higher-priority arrival does not pre-empt an outstanding offer.
    - On Valid_Out && Ready_In: if pending_next != 0, stay in OFFER with Index_Out = enc(pending_next) (no bubble). Otherwise go to IDLE and hold Index_Out at its last value.
- Encoding: enc(v) = index of the highest set bit of v; only evaluated when v != 0.
- Latency:
  - Request pulse sampled at edge t gives Valid_Out high after edge t (one cycle from pulse to offer).
  - Sustained throughput is one index per cycle with Ready_In held high.
- Overflow:
  - Set when cap[i] && pending[i] && !acc_mask[i] for any i.
  - Sticky; cleared only by reset or Clear_In.
- Clear_In (highest priority after reset):
  - At the edge: pending = 0, state = IDLE, Valid_Out = 0, Overflow_Out = 0.
  - Requests and acceptances in the same cycle are discarded.
- Ready_In while Valid_Out = 0 has no effect.
- Enable_In low: pending bits persist and continue to be offered and drained.
- All outputs are registered. Pending_Out = pending.

Decomposition:
- Shared package prio_pkg:
  - state enum {IDLE, OFFER}.
  - Constants NUM_REQ_DEF = 4, IDX_W_DEF = 2.
  - Function onehot(idx).
- Sub-module prio_enc_n: purely combinational, parameterised NUM_REQ.
  - Outputs the highest-set-bit index plus an any_set flag.
  - Instantiated once on pending_next.

Test Plan:
- Reset then Request_In = 4'b0101 for one cycle, Ready_In = 0 -> next cycle Valid_Out = 1, Index_Out = 2, Pending_Out = 0101. Held for 5 cycles, then Ready_In = 1 for one cycle -> Index_Out = 0, Valid_Out = 1. Next accept -> Valid_Out = 0, Pending_Out = 0.
- Offer Index_Out = 1 stalled; Request_In = 4'b1000 arrives -> Index_Out stays 1 until accept, then becomes 3.
- Ready_In held 1, Request_In = 4'b1111 one cycle -> Index_Out sequence 3, 2, 1, 0 on consecutive cycles with Valid_Out continuous, then Valid_Out = 0.
- Bit 2 pending but not offered (bit 3 offered, Ready_In = 0), Request_In = 4'b0100 again -> Overflow_Out = 1 next cycle and stays 1. Re-request of bit 3 on its accept cycle -> bit 3 still pending, Overflow_Out unaffected by that event.
- Enable_In = 0 with Request_In = 4'b0010 -> no capture, Valid_Out stays 0. Clear_In pulse during OFFER with pending = 1010 -> next cycle Valid_Out = 0, Pending_Out = 0, Overflow_Out = 0.
- Assert Reset_n_In low mid-clock during OFFER -> Valid_Out, Index_Out, Pending_Out = 0 immediately, before the next edge.
